// File: rtl/xain_pkg.sv
// Shared types for the SDRAM stream reader.
// Read FSM state encoding and byte-lane offsets within a 16-bit SDRAM word.
package xain_pkg;

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_ISSUE,
      RD_WAIT,
      RD_DRAIN,
      RD_ABORT
   } sdr_rd_state_t;

   localparam int LANE_LO_LSB = 0;
   localparam int LANE_HI_LSB = 8;

endpackage

// File: rtl/sdr_word_fifo.sv
// Small synchronous word FIFO between SDRAM reads and the byte stream.
// DEPTH must be a power of two; flush empties it in one cycle.
module sdr_word_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wp_q;
   logic [PW-1:0] rp_q;
   logic [PW:0]   cnt_q;
   logic          wr_ok;
   logic          rd_ok;

   assign full    = (cnt_q == (PW+1)'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem_q[rp_q];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_ok)
            wp_q <= wp_q + PW'(1);
         if (rd_ok)
            rp_q <= rp_q + PW'(1);
         cnt_q <= cnt_q + (PW+1)'(wr_ok)
                        - (PW+1)'(rd_ok);
      end
   end

   // Storage array; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem_q[wp_q] <= wr_data;
   end

endmodule

// File: rtl/sdr_stream_reader.sv
// Fetches a byte range from SDRAM over a toggle channel as a byte stream.
// Define SDR_READER_SUM_EN to add the out_sum running byte checksum.
module sdr_stream_reader
   import xain_pkg::*;
#(
   parameter int ADDR_W     = 25,
   parameter int LEN_W      = 25,
   parameter int FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] sdr_addr,
   output logic              sdr_req,
   input  logic              sdr_rdy,
   input  logic [15:0]       sdr_dout,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
`ifdef SDR_READER_SUM_EN
   ,
   output logic [15:0]       out_sum
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);

   sdr_rd_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] saddr_q, saddr_d;
   logic [LEN_W-1:0]  words_q, words_d;
   logic [LEN_W-1:0]  bytes_q, bytes_d;
   logic              lane_q, lane_d;
   logic              req_q, req_d;
   logic              done_q, done_d;
`ifdef SDR_READER_SUM_EN
   logic [15:0]       sum_q, sum_d;
`endif

   logic              fifo_wr;
   logic              fifo_flush;
   logic [15:0]       fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [PW:0]       fifo_cnt;

   logic              completed;
   logic              abort_eff;
   logic              acc;
   logic              last_acc;
   logic              pop;
   logic              slot_after;
   logic [LEN_W:0]    wc_sum;
   logic [7:0]        lane_byte;

   sdr_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (16)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush   (fifo_flush),
      .wr_en   (fifo_wr),
      .wr_data (sdr_dout),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_cnt)
   );

   assign completed = (sdr_rdy == req_q);
   assign abort_eff = abort
                   && (state_q != RD_IDLE)
                   && (state_q != RD_ABORT);

   assign lane_byte = lane_q
                    ? fifo_head[LANE_HI_LSB +: 8]
                    : fifo_head[LANE_LO_LSB +: 8];

   assign out_valid = !fifo_empty;
   assign out_data  = out_valid ? lane_byte : 8'h00;
   assign out_last  = out_valid
                   && (bytes_q == LEN_W'(1));

   assign acc      = out_valid && out_ready && !abort_eff;
   assign last_acc = acc && (bytes_q == LEN_W'(1));
   assign pop      = acc
                  && (lane_q || (bytes_q == LEN_W'(1)));

   // A slot stays free after this cycle's write unless the FIFO would fill.
   assign slot_after = pop
                    || (fifo_cnt < (PW+1)'(FIFO_DEPTH - 1));

   // Words spanned, including a leading odd byte.
   assign wc_sum = {1'b0, length}
                 + (LEN_W+1)'(start_addr[0])
                 + (LEN_W+1)'(1);

   assign busy     = (state_q != RD_IDLE);
   assign done     = done_q;
   assign sdr_req  = req_q;
   assign sdr_addr = saddr_q;
`ifdef SDR_READER_SUM_EN
   assign out_sum  = sum_q;
`endif

   // Next-state logic for the fetch FSM, counters and byte lane.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      saddr_d    = saddr_q;
      words_d    = words_q;
      bytes_d    = bytes_q;
      lane_d     = lane_q;
      req_d      = req_q;
      done_d     = 1'b0;
      fifo_wr    = 1'b0;
      fifo_flush = 1'b0;
`ifdef SDR_READER_SUM_EN
      sum_d      = sum_q;
`endif

      if (acc) begin
         bytes_d = bytes_q - LEN_W'(1);
         lane_d  = ~pop;
`ifdef SDR_READER_SUM_EN
         sum_d   = sum_q + {8'h00, out_data};
`endif
      end

      if (last_acc)
         done_d = 1'b1;

      unique case (state_q)
         RD_IDLE: begin
            if (start && !abort) begin
               addr_d  = {start_addr[ADDR_W-1:1], 1'b0};
               words_d = LEN_W'(wc_sum >> 1);
               bytes_d = length;
               lane_d  = start_addr[0];
`ifdef SDR_READER_SUM_EN
               sum_d   = '0;
`endif
               if (length == '0)
                  done_d  = 1'b1;
               else
                  state_d = RD_ISSUE;
            end
         end

         RD_ISSUE: begin
            if (abort_eff) begin
               fifo_flush = 1'b1;
               state_d    = RD_IDLE;
            end else if (completed) begin
               req_d   = ~req_q;
               saddr_d = addr_q;
               addr_d  = addr_q + ADDR_W'(2);
               words_d = words_q - LEN_W'(1);
               state_d = RD_WAIT;
            end
         end

         RD_WAIT: begin
            if (abort_eff) begin
               fifo_flush = 1'b1;
               state_d    = completed ? RD_IDLE
                                      : RD_ABORT;
            end else if (completed) begin
               fifo_wr = 1'b1;
               if ((words_q != '0) && slot_after)
                  state_d = RD_ISSUE;
               else
                  state_d = RD_DRAIN;
            end
         end

         RD_DRAIN: begin
            if (abort_eff) begin
               fifo_flush = 1'b1;
               state_d    = RD_IDLE;
            end else if (words_q != '0) begin
               if (!fifo_full)
                  state_d = RD_ISSUE;
            end else if (last_acc) begin
               state_d = RD_IDLE;
            end
         end

         RD_ABORT: begin
            if (completed)
               state_d = RD_IDLE;
         end

         default: begin
            state_d = RD_IDLE;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RD_IDLE;
         addr_q  <= '0;
         saddr_q <= '0;
         words_q <= '0;
         bytes_q <= '0;
         lane_q  <= 1'b0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         saddr_q <= saddr_d;
         words_q <= words_d;
         bytes_q <= bytes_d;
         lane_q  <= lane_d;
         req_q   <= req_d;
         done_q  <= done_d;
      end
   end

`ifdef SDR_READER_SUM_EN
   // Running byte checksum register.
   always_ff @(posedge clk) begin
      if (reset)
         sum_q <= '0;
      else
         sum_q <= sum_d;
   end
`endif

endmodule
